// File: rtl/fft_frame_capture.sv
// Frame capture controller: waits for a trigger pulse, captures FRAME_LEN
// valid samples into a block RAM, then streams them out over an
// AXI-stream-style master with back-pressure and tlast framing.
// Triggers arriving while a frame is in flight are dropped and counted.
module fft_frame_capture #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              trigger,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       drop_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        STREAM  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    state_t            state_q, state_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              rd_done_q, rd_done_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_last_q, rd_last_d;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_vld_q, out_vld_d;
    logic              out_last_q, out_last_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;

    logic              mem_we;
    logic              rd_en;
    logic              out_ready;
    logic              s1_ready;
    logic              last_hs;

    logic [DATA_W-1:0] mem [FRAME_LEN];

    // Next-state, pointer, read-pipeline and drop-counter logic
    always_comb begin
        state_d    = state_q;
        run_d      = 1'b1;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_done_d  = rd_done_q;
        rd_vld_d   = rd_vld_q;
        rd_last_d  = rd_last_q;
        out_data_d = out_data_q;
        out_vld_d  = out_vld_q;
        out_last_d = out_last_q;
        drop_cnt_d = drop_cnt_q;
        mem_we     = 1'b0;
        rd_en      = 1'b0;
        // Output register can take a new beat when empty or being drained;
        // RAM output stage can advance when empty or moving into the output
        // register. Together these give one beat per cycle under tready=1.
        out_ready  = !out_vld_q || m_tready;
        s1_ready   = !rd_vld_q || out_ready;
        last_hs    = out_vld_q && m_tready && out_last_q;

        if ((state_q != IDLE) && trigger && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                // run_q holds off triggers until reset release has settled
                if (run_q && trigger) begin
                    state_d  = CAPTURE;
                    wr_ptr_d = '0;
                end
            end
            CAPTURE: begin
                if (s_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_IDX) begin
                        state_d    = STREAM;
                        rd_ptr_d   = '0;
                        rd_done_d  = 1'b0;
                        rd_vld_d   = 1'b0;
                        rd_last_d  = 1'b0;
                        out_vld_d  = 1'b0;
                        out_last_d = 1'b0;
                    end
                end
            end
            STREAM: begin
                if (out_ready) begin
                    out_vld_d  = rd_vld_q;
                    out_last_d = rd_vld_q && rd_last_q;
                    if (rd_vld_q) begin
                        out_data_d = rd_data_q;
                    end
                end
                if (s1_ready) begin
                    if (!rd_done_q) begin
                        rd_en     = 1'b1;
                        rd_vld_d  = 1'b1;
                        rd_last_d = (rd_ptr_q == LAST_IDX);
                        rd_done_d = (rd_ptr_q == LAST_IDX);
                        rd_ptr_d  = rd_ptr_q + 1'b1;
                    end else begin
                        rd_vld_d  = 1'b0;
                        rd_last_d = 1'b0;
                    end
                end
                if (last_hs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            run_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_done_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_done_q  <= rd_done_d;
            rd_vld_q   <= rd_vld_d;
            rd_last_q  <= rd_last_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
            out_last_q <= out_last_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Frame buffer write port (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= s_data;
        end
    end

    // Frame buffer synchronous read port; holds its output when not enabled
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    assign m_tdata    = out_data_q;
    assign m_tvalid   = out_vld_q;
    assign m_tlast    = out_last_q;
    assign frame_done = last_hs;
    assign busy       = (state_q != IDLE);
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_fft_frame_capture.sv
// Testbench for fft_frame_capture with FRAME_LEN=8: randomized stimulus
// against a frame-level reference model (queue of expected samples).
module tb_fft_frame_capture;

    localparam int DW   = 32;
    localparam int FLEN = 8;
    localparam int AW   = 3;

    logic          clk;
    logic          nreset;
    logic          trigger;
    logic          trig_drv;
    logic          din;
    logic          din_q;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          busy;
    logic          frame_done;
    logic [15:0]   drop_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int rdy_pct = 100;
    int cyc_cnt = 0;
    int exp_drops = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    int fd_cnt, fd_viol, stall_viol;
    int fd_cyc, trig_cyc, first_cyc, last_cyc;
    logic busy_cap;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;

    fft_frame_capture #(.DATA_W(DW), .FRAME_LEN(FLEN), .ADDR_W(AW)) dut (
        .clk(clk), .nreset(nreset), .trigger(trigger), .s_data(s_data),
        .s_valid(s_valid), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy),
        .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // simple rising-edge detector feeding the trigger for the chain test
    always @(posedge clk) din_q <= din;
    assign trigger = trig_drv | (din & ~din_q);

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // passive monitor: collects accepted beats and protocol observations
    always @(negedge clk) begin
        if (!nreset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_data || m_tlast !== prev_last))
                stall_viol++;
            if (frame_done !== (m_tvalid & m_tready & m_tlast)) fd_viol++;
            if (m_tvalid && m_tready) begin
                if (got_data.size() == 0) first_cyc = cyc_cnt;
                last_cyc = cyc_cnt;
                got_data.push_back(m_tdata);
                got_last.push_back(m_tlast);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc_cnt + 1;
            end
            prev_stall = m_tvalid & ~m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        m_tready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    // Drives one trigger + capture + stream. The reference frame is simply
    // the first FLEN valid samples after the trigger cycle.
    task automatic drive_frame(input bit gapped, input logic [31:0] base, input int cap_trigs,
                               input int str_trigs, input bit trig_on_last, input int abort_at,
                               output bit timed_out);
        int n, cyc, k, str_left, placed;
        bit v, last_hit;
        logic [DW-1:0] d;
        exp_q.delete(); got_data.delete(); got_last.delete();
        fd_cnt = 0; fd_viol = 0; stall_viol = 0; last_hit = 1'b0;
        timed_out = 1'b0;
        trig_drv = 1'b1; s_valid = 1'b1; s_data = 32'hAA;
        step();
        trig_cyc = cyc_cnt;
        n = 0; cyc = 0;
        while (n < FLEN) begin
            v = gapped ? (cyc % 2 == 0) : 1'b1;
            d = (base != 0) ? base + n : $urandom;
            trig_drv = (cyc >= 1 && cyc <= cap_trigs);
            s_valid = v; s_data = d;
            if (v) begin exp_q.push_back(d); n++; end
            step();
            if (cyc == 0) busy_cap = busy;
            cyc++;
        end
        s_valid = 1'b1; str_left = str_trigs; k = 0;
        while (fd_cnt == 0 && k < 2000) begin
            s_data = $urandom;
            trig_drv = 1'b0;
            if (str_left > 0 && got_data.size() >= 2 && got_data.size() < FLEN - 2) begin
                trig_drv = 1'b1; str_left--;
            end
            if (trig_on_last && m_tvalid && m_tready && m_tlast) begin
                trig_drv = 1'b1; last_hit = 1'b1;
            end
            if (abort_at > 0 && got_data.size() >= abort_at) break;
            step(); k++;
        end
        trig_drv = 1'b0; s_valid = 1'b0;
        if (fd_cnt == 0 && abort_at == 0) timed_out = 1'b1;
        placed = cap_trigs + (str_trigs - str_left) + (last_hit ? 1 : 0);
        exp_drops = (exp_drops + placed > 65535) ? 65535 : exp_drops + placed;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b want 0", m_tvalid); end
        n_chk++; if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b want 0", m_tlast); end
        n_chk++; if (m_tdata !== '0) begin n_fail++; $display("FAIL rst_tdata: got %h want 0", m_tdata); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", frame_done); end
        n_chk++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_drop: got %h want 0", drop_cnt); end
        // trigger at the first edge after release must be ignored
        nreset = 1'b1; trig_drv = 1'b1;
        step();
        trig_drv = 1'b0;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_first_edge_trig: busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        bit to;
        rdy_pct = 100;
        drive_frame(1'b0, 32'h10, 0, 0, 1'b0, 0, to);
        n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0d want 0", to); end
        n_chk++; if (got_data.size() !== FLEN) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", got_data.size(), FLEN); end
        for (int i = 0; i < got_data.size() && i < FLEN; i++) begin
            n_chk++; if (got_data[i] !== 32'h10 + i) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, got_data[i], 32'h10 + i); end
            n_chk++; if (got_last[i] !== (i == FLEN - 1)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b", i, got_last[i]); end
        end
        n_chk++; if (busy_cap !== 1'b1) begin n_fail++; $display("FAIL basic_busy_trig: got %b want 1", busy_cap); end
        n_chk++; if (fd_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", fd_cnt); end
        n_chk++; if (fd_viol !== 0) begin n_fail++; $display("FAIL basic_done_align: got %0d want 0", fd_viol); end
        n_chk++; if (fd_cyc - trig_cyc !== 2 * FLEN + 2) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", fd_cyc - trig_cyc, 2 * FLEN + 2); end
        n_chk++; if (last_cyc - first_cyc !== FLEN - 1) begin n_fail++; $display("FAIL basic_throughput: got %0d want %0d", last_cyc - first_cyc, FLEN - 1); end
        n_chk++; if (busy !== 1'b0 || m_tvalid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: busy %b tvalid %b want 0 0", busy, m_tvalid); end
        n_chk++; if (drop_cnt !== 16'(exp_drops)) begin n_fail++; $display("FAIL basic_drop: got %0d want %0d", drop_cnt, exp_drops); end
    endtask

    task automatic test_gapped();
        bit to;
        rdy_pct = 100;
        drive_frame(1'b1, 32'h0, 0, 0, 1'b0, 0, to);
        n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL gap_timeout: got %0d want 0", to); end
        n_chk++; if (got_data.size() !== FLEN) begin n_fail++; $display("FAIL gap_count: got %0d want %0d", got_data.size(), FLEN); end
        for (int i = 0; i < got_data.size() && i < FLEN; i++) begin
            n_chk++; if (got_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL gap_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
            n_chk++; if (got_last[i] !== (i == FLEN - 1)) begin n_fail++; $display("FAIL gap_last[%0d]: got %b", i, got_last[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        rdy_pct = 50;
        for (int f = 0; f < 3; f++) begin
            drive_frame(f[0], 32'h0, 0, 0, 1'b0, 0, to);
            n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL bp_timeout[%0d]: got %0d want 0", f, to); end
            n_chk++; if (got_data.size() !== FLEN) begin n_fail++; $display("FAIL bp_count[%0d]: got %0d want %0d", f, got_data.size(), FLEN); end
            for (int i = 0; i < got_data.size() && i < FLEN; i++) begin
                n_chk++; if (got_data[i] !== exp_q[i] || got_last[i] !== (i == FLEN - 1)) begin
                    n_fail++; $display("FAIL bp_beat[%0d][%0d]: got %h/%b want %h", f, i, got_data[i], got_last[i], exp_q[i]);
                end
            end
            n_chk++; if (stall_viol !== 0) begin n_fail++; $display("FAIL bp_stall_stable[%0d]: got %0d violations want 0", f, stall_viol); end
            n_chk++; if (fd_cnt !== 1 || fd_viol !== 0) begin n_fail++; $display("FAIL bp_done[%0d]: cnt %0d viol %0d want 1 0", f, fd_cnt, fd_viol); end
        end
        rdy_pct = 100;
    endtask

    task automatic test_drops();
        bit to;
        rdy_pct = 100;
        drive_frame(1'b0, 32'h0, 3, 2, 1'b0, 0, to);
        repeat (20) step();
        n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL drop_timeout: got %0d want 0", to); end
        n_chk++; if (drop_cnt !== 16'd5) begin n_fail++; $display("FAIL drop_cnt: got %0d want 5", drop_cnt); end
        n_chk++; if (drop_cnt !== 16'(exp_drops)) begin n_fail++; $display("FAIL drop_model: got %0d want %0d", drop_cnt, exp_drops); end
        n_chk++; if (got_data.size() !== FLEN || fd_cnt !== 1) begin n_fail++; $display("FAIL drop_one_frame: beats %0d done %0d want %0d 1", got_data.size(), fd_cnt, FLEN); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: busy got %b want 0", busy); end
        for (int i = 0; i < got_data.size() && i < FLEN; i++) begin
            n_chk++; if (got_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL drop_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
        end
    endtask

    task automatic test_trig_timing();
        bit to;
        rdy_pct = 60;
        drive_frame(1'b0, 32'h0, 0, 0, 1'b1, 0, to);
        n_chk++; if (to !== 1'b0) begin n_fail++; $display("FAIL tt_timeout: got %0d want 0", to); end
        n_chk++; if (got_data.size() < 1 || got_data[0] !== exp_q[0]) begin n_fail++; $display("FAIL tt_first_beat: AA-cycle sample must be skipped, want %h", exp_q[0]); end
        for (int i = 1; i < got_data.size() && i < FLEN; i++) begin
            n_chk++; if (got_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL tt_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
        end
        repeat (5) step();
        n_chk++; if (drop_cnt !== 16'd6) begin n_fail++; $display("FAIL tt_last_trig_dropped: got %0d want 6", drop_cnt); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tt_no_restart: busy got %b want 0", busy); end
        rdy_pct = 100;
    endtask

    task automatic test_back_to_back();
        bit to;
        rdy_pct = 100;
        drive_frame(1'b0, 32'h0, 0, 0, 1'b0, 0, to);
        n_chk++; if (to !== 1'b0 || got_data.size() !== FLEN) begin n_fail++; $display("FAIL b2b_first: timeout %0d beats %0d want 0 %0d", to, got_data.size(), FLEN); end
        // trigger on the edge right after the last handshake
        drive_frame(1'b0, 32'h0, 0, 0, 1'b0, 0, to);
        n_chk++; if (to !== 1'b0 || got_data.size() !== FLEN) begin n_fail++; $display("FAIL b2b_second: timeout %0d beats %0d want 0 %0d", to, got_data.size(), FLEN); end
        n_chk++; if (fd_cyc - trig_cyc !== 2 * FLEN + 2) begin n_fail++; $display("FAIL b2b_latency: got %0d want %0d", fd_cyc - trig_cyc, 2 * FLEN + 2); end
        for (int i = 0; i < got_data.size() && i < FLEN; i++) begin
            n_chk++; if (got_data[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, got_data[i], exp_q[i]); end
        end
    endtask

    task automatic test_edge_chain();
        rdy_pct = 100;
        got_data.delete(); got_last.delete(); fd_cnt = 0;
        repeat (2) step();
        for (int i = 0; i < 40; i++) begin
            din = 1'b1; s_valid = 1'b1; s_data = 32'h100 + i;
            step();
        end
        din = 1'b0; s_valid = 1'b0;
        step();
        n_chk++; if (got_data.size() !== FLEN || fd_cnt !== 1) begin n_fail++; $display("FAIL chain_one_frame: beats %0d done %0d want %0d 1", got_data.size(), fd_cnt, FLEN); end
        for (int i = 0; i < got_data.size() && i < FLEN; i++) begin
            n_chk++; if (got_data[i] !== 32'h101 + i) begin n_fail++; $display("FAIL chain_data[%0d]: got %h want %h", i, got_data[i], 32'h101 + i); end
        end
        n_chk++; if (drop_cnt !== 16'(exp_drops)) begin n_fail++; $display("FAIL chain_drop: got %0d want %0d", drop_cnt, exp_drops); end
    endtask

    task automatic test_reset_mid();
        bit to;
        rdy_pct = 100;
        drive_frame(1'b0, 32'h0, 0, 0, 1'b0, 4, to);
        #2;
        n_chk++; if (busy !== 1'b1 || m_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_state: busy %b tvalid %b want 1 1", busy, m_tvalid); end
        nreset = 1'b0;
        #1;
        n_chk++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== '0) begin
            n_fail++; $display("FAIL mid_async_out: tvalid %b tlast %b tdata %h want 0", m_tvalid, m_tlast, m_tdata);
        end
        n_chk++; if (busy !== 1'b0 || frame_done !== 1'b0 || drop_cnt !== 16'd0) begin
            n_fail++; $display("FAIL mid_async_ctl: busy %b done %b drop %0d want 0", busy, frame_done, drop_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1; exp_drops = 0;
        step();
        drive_frame(1'b0, 32'h0, 0, 0, 1'b0, 0, to);
        n_chk++; if (to !== 1'b0 || got_data.size() !== FLEN) begin n_fail++; $display("FAIL mid_recover: timeout %0d beats %0d want 0 %0d", to, got_data.size(), FLEN); end
        for (int i = 0; i < got_data.size() && i < FLEN; i++) begin
            n_chk++; if (got_data[i] !== exp_q[i] || got_last[i] !== (i == FLEN - 1)) begin
                n_fail++; $display("FAIL mid_data[%0d]: got %h/%b want %h", i, got_data[i], got_last[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation();
        nreset = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1; exp_drops = 0;
        step();
        rdy_pct = 0; stall_viol = 0;
        trig_drv = 1'b1; s_valid = 1'b1; s_data = 32'h5A5A0001;
        repeat (65600) step();
        trig_drv = 1'b0; s_valid = 1'b0;
        step();
        n_chk++; if (drop_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_drop: got %h want ffff", drop_cnt); end
        n_chk++; if (m_tvalid !== 1'b1 || m_tlast !== 1'b0 || m_tdata !== 32'h5A5A0001) begin
            n_fail++; $display("FAIL sat_stall_beat: tvalid %b tlast %b tdata %h want 1 0 5a5a0001", m_tvalid, m_tlast, m_tdata);
        end
        n_chk++; if (stall_viol !== 0) begin n_fail++; $display("FAIL sat_stall_stable: got %0d want 0", stall_viol); end
    endtask

    initial begin
        nreset = 1'b0; trig_drv = 1'b0; din = 1'b0;
        s_valid = 1'b0; s_data = '0; m_tready = 1'b0;
        fd_cnt = 0; fd_viol = 0; stall_viol = 0; prev_stall = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_drops();
        test_trig_timing();
        test_back_to_back();
        test_edge_chain();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
